// File: rtl/riscv32ima_pkg.sv
// Shared RV32 decode definitions: major opcodes, branch func3 codes,
// immediate format selection and immediate generation.
package riscv32ima_pkg;

  localparam int INST_WIDTH = 32;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
  localparam logic [6:0] OPC_CUSTOM_0  = 7'b0001011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
  localparam logic [6:0] OPC_CUSTOM_1  = 7'b0101011;
  localparam logic [6:0] OPC_AMO       = 7'b0101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MADD      = 7'b1000011;
  localparam logic [6:0] OPC_MSUB      = 7'b1000111;
  localparam logic [6:0] OPC_NMSUB     = 7'b1001011;
  localparam logic [6:0] OPC_NMADD     = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP     = 7'b1010011;
  localparam logic [6:0] OPC_CUSTOM_2  = 7'b1011011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_CUSTOM_3  = 7'b1111011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_t fmt;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: fmt = IMM_I;
      OPC_STORE:                                                fmt = IMM_S;
      OPC_BRANCH:                                               fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:                                       fmt = IMM_U;
      OPC_JAL:                                                  fmt = IMM_J;
      default:                                                  fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  // Returns the 32-bit sign-extended immediate; callers widen further if needed.
  function automatic logic [31:0] gen_imm(input logic [INST_WIDTH-1:0] inst,
                                          input imm_fmt_t fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/riscv32ima_regfile.sv
// Integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, asynchronously cleared on nrst.
module riscv32ima_regfile #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [REG_ADDR_WIDTH-1:0] rd0_addr,
  output logic [REG_DATA_WIDTH-1:0] rd0_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd1_addr,
  output logic [REG_DATA_WIDTH-1:0] rd1_data,
  input  logic                      wen,
  input  logic [REG_ADDR_WIDTH-1:0] waddr,
  input  logic [REG_DATA_WIDTH-1:0] wdata
);

  localparam int DEPTH = 2 ** REG_ADDR_WIDTH;

  logic [REG_DATA_WIDTH-1:0] regs [DEPTH];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wen && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rd0_data = (rd0_addr == '0) ? '0 : regs[rd0_addr];
  assign rd1_data = (rd1_addr == '0) ? '0 : regs[rd1_addr];

endmodule

// File: rtl/riscv32ima_dec.sv
// Decode / register-read stage: splits the instruction, reads operands with
// same-cycle writeback bypass, builds the immediate and registers the result.
module riscv32ima_dec
  import riscv32ima_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 32,
  parameter int OPCODE_WIDTH   = 7,
  parameter int FUNC3_WIDTH    = 3,
  parameter int FUNC7_WIDTH    = 7
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      if_valid,
  output logic                      if_ready,
  input  logic [ADDR_WIDTH-1:0]     if_pc,
  input  logic [31:0]               if_inst,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [OPCODE_WIDTH-1:0]   dec_opcode,
  output logic [FUNC3_WIDTH-1:0]    dec_func3_opcode,
  output logic [FUNC7_WIDTH-1:0]    dec_func7_opcode,
  output logic [REG_ADDR_WIDTH-1:0] dec_src0_addr,
  output logic [REG_ADDR_WIDTH-1:0] dec_src1_addr,
  output logic [REG_ADDR_WIDTH-1:0] dec_dst_addr,
  output logic [ADDR_WIDTH-1:0]     dec_mem_addr,
  output logic [DATA_WIDTH-1:0]     dec_src0_data,
  output logic [DATA_WIDTH-1:0]     dec_src1_data,
  output logic [DATA_WIDTH-1:0]     dec_imm_data,
  input  logic                      wback_pc_wen,
  input  logic                      wback_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0] wback_reg_addr,
  input  logic [REG_DATA_WIDTH-1:0] wback_reg_data
);

  logic [OPCODE_WIDTH-1:0]   opcode;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [REG_DATA_WIDTH-1:0] rf_rd0, rf_rd1, rs1_val, rs2_val;
  logic [DATA_WIDTH-1:0]     src0_ext, src1_ext, imm_ext;
  logic [31:0]               imm32;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic                      load;

  assign opcode = if_inst[6:0];
  assign rs1    = if_inst[19:15];
  assign rs2    = if_inst[24:20];

  riscv32ima_regfile #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .REG_DATA_WIDTH(REG_DATA_WIDTH)
  ) u_regfile (
    .clk      (clk),
    .nrst     (nrst),
    .rd0_addr (rs1),
    .rd0_data (rf_rd0),
    .rd1_addr (rs2),
    .rd1_data (rf_rd1),
    .wen      (wback_reg_wen),
    .waddr    (wback_reg_addr),
    .wdata    (wback_reg_data)
  );

  // Same-cycle bypass: a write landing this edge is seen by the loading beat.
  always_comb begin
    rs1_val = rf_rd0;
    rs2_val = rf_rd1;
    if (wback_reg_wen && (wback_reg_addr != '0) && (wback_reg_addr == rs1)) rs1_val = wback_reg_data;
    if (wback_reg_wen && (wback_reg_addr != '0) && (wback_reg_addr == rs2)) rs2_val = wback_reg_data;
  end

  assign src0_ext = {{(DATA_WIDTH-REG_DATA_WIDTH){1'b0}}, rs1_val};
  assign src1_ext = {{(DATA_WIDTH-REG_DATA_WIDTH){1'b0}}, rs2_val};
  assign imm32    = gen_imm(if_inst, imm_fmt_of(opcode));
  assign imm_ext  = {{(DATA_WIDTH-32){imm32[31]}}, imm32};

  always_comb begin
    rd       = if_inst[11:7];
    mem_addr = if_pc;
    if (opcode == OPC_STORE || opcode == OPC_BRANCH) rd = '0;
    if (opcode == OPC_JALR) mem_addr = src0_ext[ADDR_WIDTH-1:0];
  end

  // Handshake: a beat transfers on if_valid & if_ready. The stage can take a
  // new beat when empty or when its current beat is being consumed
  // (dec_valid & dec_ready), but never while a PC redirect flushes it.
  // dec_* outputs stay frozen while dec_valid=1 and dec_ready=0.
  assign if_ready = (dec_ready | ~dec_valid) & ~wback_pc_wen;
  assign load     = if_valid & if_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dec_valid        <= 1'b0;
      dec_opcode       <= '0;
      dec_func3_opcode <= '0;
      dec_func7_opcode <= '0;
      dec_src0_addr    <= '0;
      dec_src1_addr    <= '0;
      dec_dst_addr     <= '0;
      dec_mem_addr     <= '0;
      dec_src0_data    <= '0;
      dec_src1_data    <= '0;
      dec_imm_data     <= '0;
    end else if (wback_pc_wen) begin
      dec_valid <= 1'b0;
    end else if (load) begin
      dec_valid        <= 1'b1;
      dec_opcode       <= opcode;
      dec_func3_opcode <= if_inst[14:12];
      dec_func7_opcode <= if_inst[31:25];
      dec_src0_addr    <= rs1;
      dec_src1_addr    <= rs2;
      dec_dst_addr     <= rd;
      dec_mem_addr     <= mem_addr;
      dec_src0_data    <= src0_ext;
      dec_src1_data    <= src1_ext;
      dec_imm_data     <= imm_ext;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv32ima_dec.sv
// Bench for riscv32ima_dec: directed scenarios plus randomized traffic
// checked against a field-level reference decoder and register model.
module tb_riscv32ima_dec;

  localparam int EW = 257;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        if_valid = 1'b0, dec_ready = 1'b0, wback_pc_wen = 1'b0, wback_reg_wen = 1'b0;
  logic [31:0] if_pc = '0, if_inst = '0, wback_reg_data = '0;
  logic [4:0]  wback_reg_addr = '0;
  logic        if_ready, dec_valid;
  logic [6:0]  dec_opcode, dec_func7_opcode;
  logic [2:0]  dec_func3_opcode;
  logic [4:0]  dec_src0_addr, dec_src1_addr, dec_dst_addr;
  logic [31:0] dec_mem_addr;
  logic [63:0] dec_src0_data, dec_src1_data, dec_imm_data;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   regs[32];
  logic          m_valid = 1'b0;
  int            n_chk = 0, n_fail = 0;

  wire [EW-1:0] dut_bus = {dec_valid, dec_opcode, dec_func3_opcode, dec_func7_opcode,
                           dec_src0_addr, dec_src1_addr, dec_dst_addr, dec_mem_addr,
                           dec_src0_data, dec_src1_data, dec_imm_data};

  riscv32ima_dec dut (
    .clk(clk), .nrst(nrst), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_inst(if_inst), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_func3_opcode(dec_func3_opcode), .dec_func7_opcode(dec_func7_opcode),
    .dec_src0_addr(dec_src0_addr), .dec_src1_addr(dec_src1_addr), .dec_dst_addr(dec_dst_addr),
    .dec_mem_addr(dec_mem_addr), .dec_src0_data(dec_src0_data), .dec_src1_data(dec_src1_data),
    .dec_imm_data(dec_imm_data), .wback_pc_wen(wback_pc_wen), .wback_reg_wen(wback_reg_wen),
    .wback_reg_addr(wback_reg_addr), .wback_reg_data(wback_reg_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wback_reg_wen && wback_reg_addr == idx) return wback_reg_data;
    return regs[idx];
  endfunction

  function automatic logic [EW-1:0] ref_decode(input logic [31:0] pc, input logic [31:0] inst);
    longint      imm;
    logic [31:0] a, b, ma;
    logic [4:0]  rd;
    a   = ref_read(inst[19:15]);
    b   = ref_read(inst[24:20]);
    rd  = inst[11:7];
    imm = 0;
    ma  = pc;
    case (inst[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0f: imm = $signed(inst[31:20]);
      7'h23: begin imm = $signed({inst[31:25], inst[11:7]}); rd = 5'd0; end
      7'h63: begin imm = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}); rd = 5'd0; end
      7'h37, 7'h17: imm = $signed(inst[31:12]) * 4096;
      7'h6f: imm = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      default: imm = 0;
    endcase
    if (inst[6:0] == 7'h67) ma = a;
    return {1'b1, inst[6:0], inst[14:12], inst[31:25], inst[19:15], inst[24:20], rd, ma,
            32'd0, a, 32'd0, b, imm};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic dr, input logic pcw, input logic rw,
                       input logic [4:0] ra, input logic [31:0] rdat);
    if_valid = iv; if_pc = pc; if_inst = inst; dec_ready = dr;
    wback_pc_wen = pcw; wback_reg_wen = rw; wback_reg_addr = ra; wback_reg_data = rdat;
    #1;
  endtask

  // Advances one clock edge and keeps the scoreboard/register model in step.
  task automatic tick();
    logic [EW-1:0] e;
    logic          ld;
    ld = if_valid && (dec_ready || !m_valid) && !wback_pc_wen;
    e  = ld ? ref_decode(if_pc, if_inst) : '0;
    @(posedge clk);
    if (wback_pc_wen) begin
      exp_q.delete(); m_valid = 1'b0;
    end else if (ld) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      exp_q.push_back(e); m_valid = 1'b1;
    end else if (dec_ready && m_valid) begin
      void'(exp_q.pop_front()); m_valid = 1'b0;
    end
    if (wback_reg_wen && wback_reg_addr != 5'd0) regs[wback_reg_addr] = wback_reg_data;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    #2 nrst = 1'b0;
    #1;
    n_chk++; if (dut_bus !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h exp 0", dut_bus); end
    n_chk++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL reset_if_ready: got %b exp 1", if_ready); end
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234); tick();
    drive(1'b1, 32'h40, 32'hFFF28313, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    n_chk++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b exp 1", dec_valid); end
    n_chk++; if (dec_opcode !== 7'h13) begin n_fail++; $display("FAIL addi_opcode: got %h exp 13", dec_opcode); end
    n_chk++; if (dec_src0_data !== 64'h1234) begin n_fail++; $display("FAIL addi_src0: got %h exp 1234", dec_src0_data); end
    n_chk++; if (dec_dst_addr !== 5'd6) begin n_fail++; $display("FAIL addi_dst: got %0d exp 6", dec_dst_addr); end
    n_chk++; if (dec_imm_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL addi_imm: got %h exp ffffffffffffffff", dec_imm_data); end
    n_chk++; if (dec_mem_addr !== 32'h40) begin n_fail++; $display("FAIL addi_mem_addr: got %h exp 40", dec_mem_addr); end
    idle();
    n_chk++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b exp 0", dec_valid); end
  endtask

  task automatic test_branch();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd1, 32'd7); tick();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'd7); tick();
    drive(1'b1, 32'h100, 32'hFE208CE3, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    n_chk++; if (dec_imm_data !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_fail++; $display("FAIL beq_imm: got %h exp fffffffffffffff8", dec_imm_data); end
    n_chk++; if (dec_dst_addr !== 5'd0) begin n_fail++; $display("FAIL beq_dst: got %0d exp 0", dec_dst_addr); end
    n_chk++; if (dec_src0_data !== 64'd7 || dec_src1_data !== 64'd7) begin n_fail++; $display("FAIL beq_src: got %h/%h exp 7/7", dec_src0_data, dec_src1_data); end
    n_chk++; if (dec_func3_opcode !== 3'd0) begin n_fail++; $display("FAIL beq_func3: got %0d exp 0", dec_func3_opcode); end
    n_chk++; if (dut_bus !== exp_q[0]) begin n_fail++; $display("FAIL beq_model: got %h exp %h", dut_bus, exp_q[0]); end
  endtask

  task automatic test_lui_bypass();
    logic [31:0] addi_x7;
    addi_x7 = {12'd1, 5'd7, 3'd0, 5'd9, 7'h13};
    drive(1'b1, 32'h200, 32'h123453B7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    n_chk++; if (dec_imm_data !== 64'h0000_0000_1234_5000) begin n_fail++; $display("FAIL lui_imm: got %h exp 12345000", dec_imm_data); end
    n_chk++; if (dec_dst_addr !== 5'd7) begin n_fail++; $display("FAIL lui_dst: got %0d exp 7", dec_dst_addr); end
    drive(1'b1, 32'h204, addi_x7, 1'b1, 1'b0, 1'b1, 5'd7, 32'hAAAA); tick();
    n_chk++; if (dec_src0_data !== 64'hAAAA) begin n_fail++; $display("FAIL bypass_src0: got %h exp aaaa", dec_src0_data); end
    drive(1'b1, 32'h208, addi_x7, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    n_chk++; if (dec_src0_data !== 64'hAAAA) begin n_fail++; $display("FAIL regfile_x7: got %h exp aaaa", dec_src0_data); end
  endtask

  task automatic test_stall();
    logic [EW-1:0] held;
    drive(1'b1, 32'h300, 32'h00A00093, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    held = exp_q[0];
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h304, 32'h0140006F, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      n_chk++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL stall_if_ready[%0d]: got %b exp 0", i, if_ready); end
      tick();
      n_chk++; if (dut_bus !== held) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h exp %h", i, dut_bus, held); end
    end
    drive(1'b1, 32'h304, 32'h0140006F, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    n_chk++; if (if_ready !== 1'b1) begin n_fail++; $display("FAIL release_if_ready: got %b exp 1", if_ready); end
    tick();
    n_chk++; if (dec_mem_addr !== 32'h304 || dec_imm_data !== 64'd20) begin n_fail++; $display("FAIL release_load: got pc %h imm %h exp 304/14", dec_mem_addr, dec_imm_data); end
    idle();
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h400, 32'h00500113, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    drive(1'b1, 32'h404, 32'h00000033, 1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF);
    n_chk++; if (if_ready !== 1'b0) begin n_fail++; $display("FAIL flush_if_ready: got %b exp 0", if_ready); end
    tick();
    n_chk++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b exp 0", dec_valid); end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    n_chk++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_not_consumed: got %b exp 0", dec_valid); end
    drive(1'b1, 32'h408, 32'h00000033, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    n_chk++; if (dec_src0_data !== 64'd0 || dec_src1_data !== 64'd0) begin n_fail++; $display("FAIL x0_read: got %h/%h exp 0/0", dec_src0_data, dec_src1_data); end
    idle();
  endtask

  task automatic test_random();
    logic [6:0]  ops[12] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0f, 7'h23,
                             7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h7f};
    logic [31:0] r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom();
      drive($urandom_range(0, 3) != 0, $urandom(), {r[31:7], ops[$urandom_range(0, 11)]},
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom());
      n_chk++;
      if (if_ready !== ((dec_ready || !m_valid) && !wback_pc_wen)) begin
        n_fail++; $display("FAIL rand_if_ready[%0d]: got %b", c, if_ready);
      end
      tick();
      n_chk++;
      if (m_valid && dut_bus !== exp_q[0]) begin
        n_fail++; $display("FAIL rand_out[%0d]: got %h exp %h", c, dut_bus, exp_q[0]);
      end else if (!m_valid && dec_valid !== 1'b0) begin
        n_fail++; $display("FAIL rand_valid[%0d]: got %b exp 0", c, dec_valid);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234); tick();
    drive(1'b1, 32'h500, 32'h00028313, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    #2 nrst = 1'b0;
    #1;
    n_chk++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid: got %b exp 0", dec_valid); end
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    exp_q.delete(); m_valid = 1'b0;
    if_valid = 1'b0;
    #10 nrst = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 32'h600, 32'h00028313, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    n_chk++; if (dec_src0_data !== 64'd0) begin n_fail++; $display("FAIL async_reset_x5: got %h exp 0", dec_src0_data); end
    n_chk++; if (dut_bus !== exp_q[0]) begin n_fail++; $display("FAIL async_reset_model: got %h exp %h", dut_bus, exp_q[0]); end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_lui_bypass();
    test_stall();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv32ima_dec.md
Name: riscv32ima_dec

Overview:
- Decode/register-read stage of the riscv32ima pipeline. Sits between instruction fetch and the ALU stage.
- Accepts one 32-bit RV32 instruction plus its PC per handshake, splits it into opcode/func/register fields and reads the 32-entry integer register file.
- Generates the sign-extended immediate and presents everything on the dec_* interface.
- Owns the register file: applies writeback from the ALU/memory side, and drops its in-flight instruction when the ALU redirects the PC.

Parameters:
- ADDR_WIDTH, 32, PC / memory address width
- DATA_WIDTH, 64, width of dec_src0_data, dec_src1_data, dec_imm_data
- REG_ADDR_WIDTH, 5, register index width
- REG_DATA_WIDTH, 32, register file word width
- OPCODE_WIDTH, 7; FUNC3_WIDTH, 3; FUNC7_WIDTH, 7, instruction field widths

Ports:
- clk  in  1  clock, rising edge
- nrst  in  1  reset, asynchronous, active-low
- if_valid  in  1  fetch offers an instruction
- if_ready  out  1  decoder accepts this cycle
- if_pc  in  ADDR_WIDTH  PC of offered instruction
- if_inst  in  32  instruction word
- dec_valid  out  1  decoded instruction valid
- dec_ready  in  1  ALU stage accepts
- dec_opcode  out  7  inst[6:0]
- dec_func3_opcode  out  3  inst[14:12]
- dec_func7_opcode  out  7  inst[31:25]
- dec_src0_addr  out  5  inst[19:15]
- dec_src1_addr  out  5  inst[24:20]
- dec_dst_addr  out  5  rd; 0 for STORE/BRANCH
- dec_mem_addr  out  ADDR_WIDTH  if_pc; for JALR, rs1 value[ADDR_WIDTH-1:0]
- dec_src0_data  out  DATA_WIDTH  rs1 value, zero-extended
- dec_src1_data  out  DATA_WIDTH  rs2 value, zero-extended
- dec_imm_data  out  DATA_WIDTH  immediate, sign-extended
- wback_pc_wen  in  1  PC redirect / flush
- wback_reg_wen  in  1  register write enable
- wback_reg_addr  in  5  write index
- wback_reg_data  in  32  write data

Behaviour:
- Clocking and reset: one clock, clk. nrst is asynchronous, active-low.
- Reset values: dec_valid=0 and every dec_* field=0. All 32 register file entries are cleared to 0.
- Pipeline register: a single output register stage. Latency is 1 cycle from an accepted fetch beat to dec_valid.
- Handshake:
  - if_ready = (dec_ready | ~dec_valid) & ~wback_pc_wen.
  - Load occurs on if_valid & if_ready; dec_valid<=1 and all fields update.
  - If the stage is draining (dec_ready=1) and no beat is loaded, dec_valid<=0.
  - With dec_valid=1 and dec_ready=0, all dec_* outputs hold stable.
- Flush: wback_pc_wen=1 forces dec_valid<=0 next edge regardless of dec_ready. The beat offered that cycle is not accepted (if_ready=0). Flush has priority over load.
- Register file:
  - Write at the edge when wback_reg_wen=1 and wback_reg_addr!=0. Writes to x0 are ignored, and x0 always reads 0.
  - Writes occur even during a flush or stall.
- Bypass: if a write targets the same nonzero index that a loading beat reads in the same cycle, wback_reg_data is used for that source. A stalled, held beat is not refreshed; hazard scheduling beyond same-cycle bypass is outside this block.
- Immediate select by opcode, all sign-extended from inst[31]:
  - I-type: LOAD, OP_IMM, JALR, SYSTEM, MISC_MEM.
  - S-type: STORE, built from {inst[31:25], inst[11:7]}.
  - B-type: BRANCH, built from {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type: LUI, AUIPC, built from {inst[31:12], 12'b0}.
  - J-type: JAL, built from {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All other opcodes: 0.
- Unknown or illegal opcodes pass through unchanged, with imm=0; the ALU default arm handles them.

Decomposition:
- Shared package riscv32ima_pkg holds:
  - the opcode constants (LOAD through custom_3) and branch func3 constants;
  - an imm_fmt_t enum {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}.
- One sub-module, riscv32ima_regfile: 32x32, two combinational read ports, one write port, x0 forced zero, asynchronous clear on nrst.
- Immediate generation is a function in the package.

Test Plan:
- Write x5=0x1234 via wback, then offer ADDI 0xFFF28313 at pc 0x40. Next cycle: dec_opcode=0x13, src0_data=0x1234, dst=6, imm=0xFFFF_FFFF_FFFF_FFFF, mem_addr=0x40.
- BEQ 0xFE208CE3 at pc 0x100 with x1=x2=7. Expect: imm=-8 (0xFFFF_FFFF_FFFF_FFF8), dst=0, src0_data=src1_data=7, func3=0.
- LUI 0x123453B7. Expect: imm=0x0000_0000_1234_5000, dst=7. Wback write x7=0xAAAA in the same cycle as a beat reading x7: src0_data=0xAAAA (bypass).
- Hold dec_ready=0 for 3 cycles with dec_valid=1 and if_valid=1. Expect: if_ready=0 and all dec_* stable. On release, the next beat loads 1 cycle later.
- Pulse wback_pc_wen with dec_valid=1, dec_ready=0, if_valid=1. Expect: dec_valid=0 next cycle and the offered beat not consumed. Wback write x0=0xFFFF, then read x0: expect 0.
- Deassert nrst mid-stream, asynchronous to clk. Expect: dec_valid=0 immediately; after release, x5 reads 0.
